cdb_slot_scheduler: RTL and testbench

- Issue-side scheduler for the common data bus (CDB) in the Tomasulo core.
- Four fixed-latency functional units (integer ALU, load/store, multiplier, divider) each carry results through a fixed-depth delay pipe. Each unit therefore writes the CDB exactly LATi cycles after issue.
- The block keeps a reservation table of future CDB cycles and grants issue only when the unit's write-back slot is free. This guarantees at most one CDB writer per cycle.
- It also replays each granted owner ID and tag on the cycle that owner drives the CDB.

---
 rtl/cdb_slot_scheduler.sv | 107 ++++++++++
 tb/tb_cdb_slot_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cdb_slot_scheduler.sv
// CDB slot scheduler: reserves future common-data-bus cycles for four fixed-latency
// units, so that at most one writer drives the CDB per cycle. It replays owner and tag on that cycle.
module cdb_slot_scheduler #(
  parameter int MAX_LAT = 8,
  parameter int LAT0    = 1,
  parameter int LAT1    = 3,
  parameter int LAT2    = 4,
  parameter int LAT3    = 6,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*TAG_W-1:0] req_tag,
  output logic [3:0]         grant,
  output logic [3:0]         slot_free,
  output logic               cdb_valid,
  output logic [1:0]         cdb_owner,
  output logic [TAG_W-1:0]   cdb_tag
);

  if (LAT0 < 1 || LAT0 >= MAX_LAT || LAT1 < 1 || LAT1 >= MAX_LAT ||
      LAT2 < 1 || LAT2 >= MAX_LAT || LAT3 < 1 || LAT3 >= MAX_LAT) begin : g_bad_lat
    $error("cdb_slot_scheduler: every LATi must lie in 1..MAX_LAT-1");
  end

  logic [MAX_LAT-1:0] v;
  logic [1:0]         own [MAX_LAT];
  logic [TAG_W-1:0]   tag [MAX_LAT];
  logic [1:0]         rr_ptr;
  logic [1:0]         rr_nxt;
  logic [3:0]         elig;
  logic [3:0]         grant_c;

  function automatic int lat_of(input int idx);
    case (idx)
      0:       return LAT0;
      1:       return LAT1;
      2:       return LAT2;
      default: return LAT3;
    endcase
  endfunction

  // Distance of a requester from the round-robin pointer in the scan order.
  function automatic logic [1:0] scan_pos(input int idx, input logic [1:0] ptr);
    return 2'(idx) - ptr;
  endfunction

  assign slot_free = {~v[LAT3], ~v[LAT2], ~v[LAT1], ~v[LAT0]};
  assign elig      = req & slot_free;

  always_comb begin
    logic win;
    logic cont;
    grant_c = '0;
    rr_nxt  = rr_ptr;
    // Scan downward so the smallest contended winner sets the pointer last.
    for (int i = 3; i >= 0; i--) begin
      win  = elig[i];
      cont = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (j != i && lat_of(j) == lat_of(i) && elig[j]) begin
          cont = 1'b1;
          if (scan_pos(j, rr_ptr) < scan_pos(i, rr_ptr)) win = 1'b0;
        end
      end
      grant_c[i] = win & rst;
      if (win && cont) rr_nxt = 2'(i + 1);
    end
  end

  assign grant = grant_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v      <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < MAX_LAT; k++) begin
        own[k] <= '0;
        tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MAX_LAT - 1; k++) begin
        v[k]   <= v[k+1];
        own[k] <= own[k+1];
        tag[k] <= tag[k+1];
      end
      v[MAX_LAT-1]   <= 1'b0;
      own[MAX_LAT-1] <= '0;
      tag[MAX_LAT-1] <= '0;
      // Granted slots land one below LATi because the table shifts on the same edge.
      for (int i = 0; i < 4; i++) begin
        if (grant_c[i]) begin
          v[lat_of(i)-1]   <= 1'b1;
          own[lat_of(i)-1] <= 2'(i);
          tag[lat_of(i)-1] <= req_tag[i*TAG_W +: TAG_W];
        end
      end
      rr_ptr <= rr_nxt;
    end
  end

  assign cdb_valid = v[0];
  assign cdb_owner = v[0] ? own[0] : 2'b00;
  assign cdb_tag   = v[0] ? tag[0] : '0;

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Bench for cdb_slot_scheduler: default latencies (dut 0) and a LAT2 = LAT3 = 4
// instance (dut 1) for round-robin arbitration, driven cycle by cycle in lockstep.
module tb_cdb_slot_scheduler;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic [3:0]       req0, req1;
  logic [19:0]      req_tag0, req_tag1;
  logic [3:0]       grant0, grant1, slot_free0, slot_free1;
  logic             cdb_valid0, cdb_valid1;
  logic [1:0]       cdb_owner0, cdb_owner1;
  logic [TAG_W-1:0] cdb_tag0, cdb_tag1;

  cdb_slot_scheduler #(.MAX_LAT(8), .LAT0(1), .LAT1(3), .LAT2(4), .LAT3(6), .TAG_W(TAG_W)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .req_tag(req_tag0), .grant(grant0),
    .slot_free(slot_free0), .cdb_valid(cdb_valid0), .cdb_owner(cdb_owner0), .cdb_tag(cdb_tag0)
  );

  cdb_slot_scheduler #(.MAX_LAT(8), .LAT0(1), .LAT1(3), .LAT2(4), .LAT3(4), .TAG_W(TAG_W)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_tag(req_tag1), .grant(grant1),
    .slot_free(slot_free1), .cdb_valid(cdb_valid1), .cdb_owner(cdb_owner1), .cdb_tag(cdb_tag1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  r0;
    logic [19:0] t0;
    logic [3:0]  g0;
    logic [3:0]  r1;
    logic [19:0] t1;
    logic [3:0]  g1;
  } vec_t;

  typedef struct {
    int         dut;
    int         cyc;
    logic [1:0] own;
    logic [4:0] tag;
  } cdb_t;

  localparam int NVEC = 40;
  vec_t tbl [NVEC];
  cdb_t sb [$];
  int   lat_d0 [4] = '{1, 3, 4, 6};
  int   lat_d1 [4] = '{1, 3, 4, 4};

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit known = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_cdb(input int d, input logic vld, input logic [1:0] own, input logic [4:0] tg);
    int idx;
    idx = -1;
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].dut == d && sb[k].cyc == cyc) idx = k;
    if (idx >= 0) begin
      cmp($sformatf("cdb_valid%0d", d), 32'(vld), 32'd1);
      cmp($sformatf("cdb_owner%0d", d), 32'(own), 32'(sb[idx].own));
      cmp($sformatf("cdb_tag%0d", d), 32'(tg), 32'(sb[idx].tag));
      sb.delete(idx);
    end else begin
      cmp($sformatf("cdb_valid%0d", d), 32'(vld), 32'd0);
      cmp($sformatf("cdb_owner%0d", d), 32'(own), 32'd0);
      cmp($sformatf("cdb_tag%0d", d), 32'(tg), 32'd0);
    end
  endtask

  // One bus cycle: check grants and CDB mid-cycle, schedule expected writes, advance.
  task automatic tick(input logic [3:0] eg0, input logic [3:0] eg1);
    cdb_t e;
    @(negedge clk);
    cmp("grant0", 32'(grant0), 32'(eg0));
    cmp("grant1", 32'(grant1), 32'(eg1));
    if (known) begin
      check_cdb(0, cdb_valid0, cdb_owner0, cdb_tag0);
      check_cdb(1, cdb_valid1, cdb_owner1, cdb_tag1);
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (eg0[i]) begin
          e.dut = 0; e.cyc = cyc + lat_d0[i]; e.own = 2'(i); e.tag = req_tag0[i*5 +: 5];
          sb.push_back(e);
        end
        if (eg1[i]) begin
          e.dut = 1; e.cyc = cyc + lat_d1[i]; e.own = 2'(i); e.tag = req_tag1[i*5 +: 5];
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst) begin
      known = 1'b1;
      sb.delete();
    end
    #1;
  endtask

  task automatic drive(input logic rn, input logic [3:0] r0, input logic [19:0] t0,
                       input logic [3:0] r1, input logic [19:0] t1);
    rst = rn; req0 = r0; req_tag0 = t0; req1 = r1; req_tag1 = t1;
  endtask

  task automatic set_row(input int c, input logic rn, input logic [3:0] r0, input logic [19:0] t0,
                         input logic [3:0] g0, input logic [3:0] r1, input logic [19:0] t1,
                         input logic [3:0] g1);
    tbl[c] = '{rn, r0, t0, g0, r1, t1, g1};
  endtask

  initial begin
    for (int c = 0; c < NVEC; c++) set_row(c, 1'b1, 4'b0, 20'h0, 4'b0, 4'b0, 20'h0, 4'b0);
    set_row(0,  1'b0, 4'b1111, 20'hFFFFF, 4'b0000, 4'b1111, 20'hFFFFF, 4'b0000);
    set_row(1,  1'b0, 4'b1111, 20'hFFFFF, 4'b0000, 4'b1111, 20'hFFFFF, 4'b0000);
    set_row(10, 1'b1, 4'b0010, {5'h0, 5'h0, 5'h15, 5'h0}, 4'b0010, 4'b0, 20'h0, 4'b0);
    set_row(12, 1'b1, 4'b0001, {5'h0, 5'h0, 5'h0, 5'h0A}, 4'b0000, 4'b0, 20'h0, 4'b0);
    set_row(13, 1'b1, 4'b0001, {5'h0, 5'h0, 5'h0, 5'h0A}, 4'b0001, 4'b0, 20'h0, 4'b0);
    set_row(17, 1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1111, 4'b0, 20'h0, 4'b0);
    set_row(20, 1'b1, 4'b0, 20'h0, 4'b0, 4'b1100, {5'h0D, 5'h0C, 10'h0}, 4'b0100);
    set_row(21, 1'b1, 4'b0, 20'h0, 4'b0, 4'b1100, {5'h0D, 5'h0C, 10'h0}, 4'b1000);
    set_row(22, 1'b1, 4'b0, 20'h0, 4'b0, 4'b1100, {5'h0D, 5'h0C, 10'h0}, 4'b0100);
    set_row(24, 1'b1, 4'b0100, {5'h0, 5'h07, 10'h0}, 4'b0100, 4'b0, 20'h0, 4'b0);
    set_row(25, 1'b1, 4'b1000, {5'h09, 15'h0}, 4'b1000, 4'b0, 20'h0, 4'b0);
    set_row(26, 1'b1, 4'b0010, {5'h0, 5'h0, 5'h11, 5'h0}, 4'b0010, 4'b0, 20'h0, 4'b0);
    set_row(27, 1'b1, 4'b0001, {15'h0, 5'h03}, 4'b0000, 4'b0, 20'h0, 4'b0);
    set_row(28, 1'b1, 4'b0001, {15'h0, 5'h03}, 4'b0000, 4'b0, 20'h0, 4'b0);
    set_row(29, 1'b1, 4'b0001, {15'h0, 5'h03}, 4'b0001, 4'b0, 20'h0, 4'b0);
    set_row(30, 1'b1, 4'b1111, {5'h1C, 5'h1D, 5'h1E, 5'h1F}, 4'b1110, 4'b0, 20'h0, 4'b0);

    drive(1'b0, 4'b0, 20'h0, 4'b0, 20'h0);
    @(posedge clk);
    #1;
    cyc = 0;

    for (int c = 0; c < NVEC; c++) begin
      drive(tbl[c].rst_n, tbl[c].r0, tbl[c].t0, tbl[c].r1, tbl[c].t1);
      tick(tbl[c].g0, tbl[c].g1);
    end

    // Reset while reservations are in flight, then a same-latency conflict.
    drive(1'b1, 4'b1100, {5'h06, 5'h05, 10'h0}, 4'b0100, {5'h0, 5'h08, 10'h0});
    tick(4'b1100, 4'b0100);
    drive(1'b1, 4'b0, 20'h0, 4'b0, 20'h0);
    tick(4'b0, 4'b0);
    drive(1'b0, 4'b1111, 20'hFFFFF, 4'b1111, 20'hFFFFF);
    tick(4'b0, 4'b0);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'b0, 20'h0, 4'b0, 20'h0);
      tick(4'b0, 4'b0);
    end
    drive(1'b1, 4'b0, 20'h0, 4'b1100, {5'h13, 5'h12, 10'h0});
    tick(4'b0, 4'b0100);
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 4'b0, 20'h0, 4'b0, 20'h0);
      tick(4'b0, 4'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
